block_data_memory: RTL and testbench
====================================

// Module: block_data_memory
// PURPOSE
//   Block-addressed main data memory directly downstream of the data cache.
//   Serves whole 32-bit cache blocks on cache-line fills (read) and dirty-block
//   write-backs (write) after a fixed, parameterised access latency, and
//   stalls the cache through a busywait handshake.
//   64 blocks x 32 bits by default; the cache forms the address as {tag,index}.
// PARAMETERS
//   ADDR_W         6   block address width (2**ADDR_W blocks)
//   BLOCK_W        32  block (data) width in bits
//   ACCESS_CYCLES  5   BUSY-state cycles per access; legal range >= 1
// PORTS
//   clock      in   1        single clock; all state changes on posedge
//   reset      in   1        synchronous, active-high
//   read       in   1        block read request, level, held until busywait low
//   write      in   1        block write request, level, held until busywait low
//   address    in   ADDR_W   block address
//   writedata  in   BLOCK_W  block to store on write
//   readdata   out  BLOCK_W  block returned by the last completed read
//   busywait   out  1        high while a request is pending or in service
// BEHAVIOUR
// - Reset, sampled at posedge: state=IDLE, counter=0, readdata=0, every
//   storage block=0, latched request cleared. busywait=0 in the cycle after
//   reset is sampled. Reset mid-access aborts it; no write is committed.
// - States: IDLE, BUSY, DONE.
// - busywait is combinational:
//   (state==IDLE && (read ^ write)) || state==BUSY.
//   It is therefore high in the same cycle a request is first presented.
// - IDLE: if read^write at posedge, latch op, address and writedata;
//   counter <= ACCESS_CYCLES-1; go to BUSY. Otherwise stay in IDLE.
// - read && write together is illegal: treated as no request; busywait
//   stays 0, no state change, storage untouched.
// - BUSY: inputs ignored; the latched copies are used.
//   If counter!=0 at posedge, decrement.
//   If counter==0 at posedge: a write stores the latched writedata at the
//   latched address; a read loads readdata from the latched address.
//   Then go to DONE.
// - DONE: lasts exactly one cycle with busywait=0 and readdata valid.
//   read/write are ignored in DONE. Next state is IDLE unconditionally.
//   The requester must drop its request at the edge that ends DONE.
// - Latency: request first high in cycle N -> busywait high in cycles
//   N..N+ACCESS_CYCLES; low in DONE cycle N+ACCESS_CYCLES+1.
// - readdata holds its value until the next completed read; writes never
//   change it.
// - A request still high in the IDLE cycle after DONE is a new access.
//   Back-to-back throughput: one access per ACCESS_CYCLES+2 cycles.
// - Write then read of the same block returns the new data; no
//   forwarding is needed because accesses are serialised.
// - Address is fully decoded; no wrap or out-of-range case exists.
// TESTING (ACCESS_CYCLES=5)
//   1. After reset, read addr 0x05 -> busywait high 6 cycles (N..N+5),
//      low at N+6 with readdata=0x00000000.
//   2. Write 0xDEADBEEF to 0x2A, then read 0x2A -> 0xDEADBEEF;
//      read 0x2B -> 0x00000000; readdata unchanged across the write.
//   3. Write to 0x10 with 0x12345678; change address/writedata to 0x11 /
//      0xFFFFFFFF during BUSY -> 0x10 holds 0x12345678, 0x11 stays 0.
//   4. read=write=1 for 10 cycles -> busywait stays 0, no storage change;
//      a following read of that address returns its previous value.
//   5. Write 0xCAFEF00D to 0x3F; assert reset in the 3rd BUSY cycle ->
//      busywait=0 the next cycle; read 0x3F -> 0x00000000.
//   6. Hold read of 0x01 through DONE and beyond -> DONE ignores it; a new
//      access starts in the next IDLE cycle with a second 6-cycle busywait.

Source files
------------

// File: rtl/block_data_memory.sv
// Block-addressed main data memory behind the data cache: whole-block fills and
// write-backs after a fixed access latency, with a busywait stall handshake.
module block_data_memory #(
   parameter int ADDR_W        = 6,
   parameter int BLOCK_W       = 32,
   parameter int ACCESS_CYCLES = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               read,
   input  logic               write,
   input  logic [ADDR_W-1:0]  address,
   input  logic [BLOCK_W-1:0] writedata,
   output logic [BLOCK_W-1:0] readdata,
   output logic               busywait
);

   localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic               op_write;
   logic [ADDR_W-1:0]  addr_l;
   logic [BLOCK_W-1:0] wdata_l;
   logic [BLOCK_W-1:0] mem [DEPTH];

   logic req;

   // Asserting read and write together is not a request at all.
   assign req      = read ^ write;
   assign busywait = ((state == IDLE) && req) || (state == BUSY);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         counter  <= '0;
         readdata <= '0;
         op_write <= 1'b0;
         addr_l   <= '0;
         wdata_l  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_write <= write;
                  addr_l   <= address;
                  wdata_l  <= writedata;
                  counter  <= CNT_LOAD;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               // Only the latched request is used here; live inputs may change.
               if (counter != '0) begin
                  counter <= counter - CNT_W'(1);
               end else begin
                  if (op_write) begin
                     mem[addr_l] <= wdata_l;
                  end else begin
                     readdata <= mem[addr_l];
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: a vector table of complete accesses plus
// hand-written sequences for mid-access input changes, illegal requests and reset.
module tb_block_data_memory;

   logic        clock;
   logic        reset;
   logic        read;
   logic        write;
   logic [5:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busywait;

   int checks = 0;
   int errors = 0;

   block_data_memory #(
      .ADDR_W(6),
      .BLOCK_W(32),
      .ACCESS_CYCLES(5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .read(read),
      .write(write),
      .address(address),
      .writedata(writedata),
      .readdata(readdata),
      .busywait(busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      int          busy;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Counts busywait-high cycles from the current sample point; bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (busywait === 1'b1 && n < 20) begin
         n++;
         @(negedge clock);
         #1;
      end
   endtask

   task automatic access(input logic rd, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, input int exp_busy,
                         input logic [31:0] exp_rd, input string name);
      int n;
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = d;
      #1;
      count_busy(n);
      check({name, " busy cycles"}, 32'(n), 32'(exp_busy));
      check({name, " readdata"}, readdata, exp_rd);
      read = 1'b0; write = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;

      vecs[0]  = '{1'b1, 1'b0, 6'h05, 32'h0,        6, 32'h00000000};
      vecs[1]  = '{1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 6, 32'h00000000};
      vecs[2]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        6, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 1'b0, 6'h2B, 32'h0,        6, 32'h00000000};
      vecs[4]  = '{1'b0, 1'b1, 6'h2B, 32'h11111111, 6, 32'h00000000};
      vecs[5]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        6, 32'hDEADBEEF};
      vecs[6]  = '{1'b1, 1'b0, 6'h2B, 32'h0,        6, 32'h11111111};
      vecs[7]  = '{1'b1, 1'b1, 6'h2A, 32'h0,        0, 32'h11111111};
      vecs[8]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        6, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b1, 6'h3F, 32'hA5A5A5A5, 6, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b0, 6'h3F, 32'h0,        6, 32'hA5A5A5A5};
      vecs[11] = '{1'b1, 1'b0, 6'h00, 32'h0,        6, 32'h00000000};

      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset busywait", 32'(busywait), 32'h0);
      check("reset readdata", readdata, 32'h0);

      for (int i = 0; i < 12; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].busy, vecs[i].exp_rd, $sformatf("vec%0d", i));
      end

      // Inputs changed while BUSY must not affect the latched write.
      @(negedge clock);
      write = 1'b1; address = 6'h10; writedata = 32'h12345678;
      #1;
      check("latch busy first", 32'(busywait), 32'h1);
      @(negedge clock);
      address = 6'h11; writedata = 32'hFFFFFFFF;
      #1;
      count_busy(n);
      check("latch busy tail", 32'(n), 32'd5);
      write = 1'b0;
      access(1'b1, 1'b0, 6'h10, 32'h0, 6, 32'h12345678, "latch rd10");
      access(1'b1, 1'b0, 6'h11, 32'h0, 6, 32'h00000000, "latch rd11");

      // Simultaneous read and write held for ten cycles is no request.
      @(negedge clock);
      read = 1'b1; write = 1'b1; address = 6'h2A; writedata = 32'h0BADF00D;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("illegal busy c%0d", i), 32'(busywait), 32'h0);
         @(negedge clock);
      end
      read = 1'b0; write = 1'b0;
      access(1'b1, 1'b0, 6'h2A, 32'h0, 6, 32'hDEADBEEF, "illegal rd2A");

      // Reset in the third BUSY cycle aborts the write and clears storage.
      @(negedge clock);
      write = 1'b1; address = 6'h3F; writedata = 32'hCAFEF00D;
      repeat (3) @(negedge clock);
      reset = 1'b1; write = 1'b0;
      @(negedge clock);
      #1;
      check("abort busywait", 32'(busywait), 32'h0);
      check("abort readdata", readdata, 32'h0);
      reset = 1'b0;
      access(1'b1, 1'b0, 6'h3F, 32'h0, 6, 32'h00000000, "abort rd3F");
      access(1'b1, 1'b0, 6'h10, 32'h0, 6, 32'h00000000, "abort rd10");

      // A read held through DONE becomes a second access in the next IDLE cycle.
      access(1'b0, 1'b1, 6'h01, 32'h77777777, 6, 32'h00000000, "hold wr01");
      @(negedge clock);
      read = 1'b1; address = 6'h01;
      #1;
      count_busy(n);
      check("hold first busy", 32'(n), 32'd6);
      check("hold done readdata", readdata, 32'h77777777);
      @(negedge clock);
      #1;
      check("hold restart busy", 32'(busywait), 32'h1);
      count_busy(n);
      check("hold second busy", 32'(n), 32'd6);
      read = 1'b0;
      @(negedge clock);
      #1;
      check("hold final idle", 32'(busywait), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
